sevseg_scan_ctrl: RTL and testbench
===================================

SEVSEG_SCAN_CTRL -- requirements
Module: sevseg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, the number of display digits (1..8).
REQ-002 SHALL have parameter INVERT, default 1; 1 = active-low segments and anodes, 0 = active-high.
REQ-003 SHALL have parameter SCAN_DIV, default 50000, the clk cycles per digit dwell (>=2).
REQ-004 SHALL have port clk  in  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have port in_data  in  4*DIGITS  binary value to display.
REQ-007 SHALL have port in_dec  in  1  1 = decimal display, 0 = hex display; sampled at handshake.
REQ-008 SHALL have port in_valid  in  1  source offers in_data/in_dec.
REQ-009 SHALL have port in_ready  out  1  block can accept; transfer when in_valid && in_ready.
REQ-010 SHALL have port ovf  out  1  last accepted decimal value exceeded 10^DIGITS-1.
REQ-011 SHALL have port seg  out  7  segments g..a of the scanned digit, bit0 = a.
REQ-012 SHALL have port an  out  DIGITS  one-hot digit enable; bit i = digit i (digit 0 least significant).

Function
REQ-013 SHALL implement FSM states IDLE and CONV; in_ready = 1 only in IDLE.
REQ-014 SHALL, on a hex handshake (in_dec=0), load nibble i of in_data into display digit i, visible in the display register the next cycle, and stay in IDLE.
REQ-015 SHALL, on a decimal handshake with in_data <= 10^DIGITS-1, enter CONV and run shift-add-3 (double-dabble) conversion, one input bit per cycle, for 4*DIGITS cycles.
REQ-016 SHALL, at the end of the last CONV cycle, write the BCD result to the display register and return to IDLE.
REQ-017 SHALL make the BCD result visible in the display register 4*DIGITS+1 cycles after the handshake edge.
REQ-018 SHALL, on a decimal handshake with in_data > 10^DIGITS-1, skip CONV, set ovf=1, and show dash (segment g only) on every digit from the next cycle.
REQ-019 SHALL clear ovf on any accepted handshake that does not overflow.
REQ-020 SHALL ignore in_valid while in CONV; the display keeps its previous content until conversion completes.
REQ-021 SHALL run a prescaler 0..SCAN_DIV-1 continuously; at each wrap, the digit index advances by 1, wrapping DIGITS-1 -> 0.
REQ-022 SHALL drive seg/an from registers updated every cycle from the current index and display register, with 1-cycle latency.
REQ-023 SHALL decode the nibble-to-segment map as 0..F standard glyphs, e.g. 0=1000000, 1=1111001, A=0001000, F=0001110 (active-low form).
REQ-024 SHALL apply INVERT to seg and an together: active-low with INVERT=1, bitwise complement with INVERT=0.
REQ-025 SHALL leave scanning uninterrupted by handshakes, CONV, or ovf.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set the FSM to IDLE and clear the prescaler, digit index, display register (all zero), and ovf.
REQ-027 SHALL drive all anodes inactive and all segments off after reset: an=all 1, seg=1111111 for INVERT=1.
REQ-028 SHALL, on reset during CONV, abort the conversion with no partial display write.
REQ-029 SHALL assert in_ready=1 on the first cycle after rst_n rises.

Configuration
REQ-030 SHALL, with SEVSEG_LZB_EN defined, blank (all segments off) every digit above the most significant non-zero digit; digit 0 is never blanked, and dashes on ovf are never blanked.
REQ-031 SHALL, without SEVSEG_LZB_EN, display all digits including leading zeros.

Structure
REQ-032 SHALL take the following from shared package sevseg_pkg: segment pattern constants (0..F, dash, blank), FSM state typedef, and a pow10 limit function.
REQ-033 SHALL instantiate sub-module sevseg_decode: nibble plus blank/dash flags -> 7-bit pattern, with INVERT applied.

Verification (DIGITS=4, SCAN_DIV=4, INVERT=1)
REQ-034 SHALL cover: reset -> an=1111, seg=1111111, in_ready=1, ovf=0.
REQ-035 SHALL cover: hex 16'h1A3F -> digit0 seg=0001110 an=1110; digit1 0110000 an=1101; digit2 0001000 an=1011; digit3 1111001 an=0111; each held 4 cycles.
REQ-036 SHALL cover: decimal 16'd1234 -> in_ready=0 for 16 cycles; then digits 3..0 show 1,2,3,4; in_valid pulses during CONV ignored.
REQ-037 SHALL cover: decimal 16'd10000 -> ovf=1 next cycle, all digits seg=0111111; then hex 16'h0005 -> ovf=0.
REQ-038 SHALL cover: rst_n=0 at CONV cycle 8 -> display stays all-zero/blank and FSM is IDLE.
REQ-039 SHALL cover: with SEVSEG_LZB_EN, hex 16'h000A -> digits 3..1 seg=1111111 and digit 0 seg=0001000.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan controller: glyph patterns
// (active-low, bit0 = segment a), FSM state type and decimal limit helper.
package sevseg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // 10^n as a 32-bit value; n up to 9 fits.
  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] r;
    r = 32'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  // Hex nibble to active-low glyph.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/sevseg_decode.sv
// Nibble to seven-segment pattern with dash/blank override and output polarity.
module sevseg_decode
  import sevseg_pkg::*;
#(
  parameter int unsigned INVERT = 1
) (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] pat;

  // Select glyph (dash beats blank beats digit), then apply polarity.
  always_comb begin
    pat = SEG_BLANK;
    if (dash)       pat = SEG_DASH;
    else if (blank) pat = SEG_BLANK;
    else            pat = seg_glyph(nib);
    seg = (INVERT != 0) ? pat : ~pat;
  end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment display controller with hex or decimal
// (double-dabble) input and continuous digit scanning.
// Optional build macro: SEVSEG_LZB_EN enables leading-zero blanking.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned INVERT   = 1,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic                  in_dec,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BW = $clog2(W) + 1;

  localparam logic [W-1:0]      LIMIT   = W'(pow10(DIGITS) - 32'd1);
  localparam logic [6:0]        SEG_OFF = (INVERT != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (INVERT != 0) ? '1 : '0;

  state_t          state;
  logic [W-1:0]    disp;
  logic [W-1:0]    sh;
  logic [W-1:0]    bcd;
  logic [W-1:0]    bcd_adj;
  logic [W-1:0]    bcd_nxt;
  logic [BW-1:0]   bitcnt;
  logic            ovf_r;
  logic [PW-1:0]   pcnt;
  logic [IW-1:0]   idx;
  logic [3:0]      cur_nib;
  logic            cur_blank;
  logic [6:0]      dec_seg;
  logic [DIGITS-1:0] onehot;

  assign in_ready = (state == IDLE);
  assign ovf      = ovf_r;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next input bit.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_nxt    = bcd_adj << 1;
    bcd_nxt[0] = sh[W-1];
  end

  // Input handshake, conversion sequencing and display register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      disp   <= '0;
      ovf_r  <= 1'b0;
      sh     <= '0;
      bcd    <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_dec) begin
              disp  <= in_data;
              ovf_r <= 1'b0;
            end else if (in_data > LIMIT) begin
              ovf_r <= 1'b1;
            end else begin
              ovf_r  <= 1'b0;
              sh     <= in_data;
              bcd    <= '0;
              bitcnt <= '0;
              state  <= CONV;
            end
          end
        end
        CONV: begin
          bcd    <= bcd_nxt;
          sh     <= sh << 1;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == BW'(W - 1)) begin
            disp  <= bcd_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running prescaler stepping the scanned digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (pcnt == PW'(SCAN_DIV - 1)) begin
      pcnt <= '0;
      idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign cur_nib = disp[4*idx +: 4];

`ifdef SEVSEG_LZB_EN
  logic [DIGITS-1:0] blank_vec;
  logic              nz;

  // Blank a digit when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank_vec = '0;
    nz        = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      nz = nz | (disp[4*(DIGITS-1-k) +: 4] != 4'd0);
      blank_vec[DIGITS-1-k] = ~nz;
    end
    blank_vec[0] = 1'b0;
  end

  assign cur_blank = blank_vec[idx];
`else
  assign cur_blank = 1'b0;
`endif

  sevseg_decode #(
    .INVERT(INVERT)
  ) u_decode (
    .nib   (cur_nib),
    .blank (cur_blank),
    .dash  (ovf_r),
    .seg   (dec_seg)
  );

  // One-hot anode for the current index.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  // Registered display outputs, refreshed every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= dec_seg;
      an  <= (INVERT != 0) ? ~onehot : onehot;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Self-checking bench for sevseg_scan_ctrl (DIGITS=4, SCAN_DIV=4, INVERT=1).
// Reference model keeps the shown digits as an integer array and derives the
// scan position from the count of clock edges since reset.
module tb_sevseg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_dec = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  sevseg_scan_ctrl #(
    .DIGITS   (ND),
    .INVERT   (1),
    .SCAN_DIV (SD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_dec   (in_dec),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ovf      (ovf),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Model state
  int unsigned n_edges = 0;
  int  dig  [ND];
  int  pend [ND];
  bit  movf = 1'b0;
  int  conv_left = 0;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    bit blank;
    blank = 1'b0;
`ifdef SEVSEG_LZB_EN
    if (i > 0) begin
      blank = 1'b1;
      for (int j = i; j < ND; j++) if (dig[j] != 0) blank = 1'b0;
    end
`endif
    if (movf)  return 7'b0111111;
    if (blank) return 7'b1111111;
    return glyph(dig[i]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic tick(input bit rst, input bit v, input bit d, input logic [15:0] data,
                      input string tag);
    logic [6:0] eseg;
    logic [3:0] ean;
    int idx;
    rst_n    = !rst;
    in_valid = v;
    in_dec   = d;
    in_data  = data;
    if (rst) begin
      eseg = 7'h7F;
      ean  = 4'hF;
      n_edges = 0;
      movf = 1'b0;
      conv_left = 0;
      for (int k = 0; k < ND; k++) dig[k] = 0;
    end else begin
      n_edges++;
      idx  = int'(((n_edges - 1) / SD) % ND);
      eseg = exp_seg(idx);
      ean  = ~(4'b0001 << idx);
      if (conv_left > 0) begin
        conv_left--;
        if (conv_left == 0) dig = pend;
      end else if (v) begin
        if (!d) begin
          for (int k = 0; k < ND; k++) dig[k] = int'((data >> (4*k)) & 16'hF);
          movf = 1'b0;
        end else if (int'(data) > 9999) begin
          movf = 1'b1;
        end else begin
          movf = 1'b0;
          conv_left = 4 * ND;
          for (int k = 0; k < ND; k++) pend[k] = (int'(data) / (10 ** k)) % 10;
        end
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".seg"},   32'(seg),      32'(eseg));
    chk({tag, ".an"},    32'(an),       32'(ean));
    chk({tag, ".ready"}, 32'(in_ready), 32'(conv_left == 0));
    chk({tag, ".ovf"},   32'(ovf),      32'(movf));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    bit rr, rv, rdec;

    // Reset state
    repeat (3) tick(1, 0, 0, 16'h0, "reset");
    repeat (8) tick(0, 0, 0, 16'h0, "idle0");

    // Hex load, watch two full scan rounds
    tick(0, 1, 0, 16'h1A3F, "hex_hs");
    repeat (34) tick(0, 0, 0, 16'h0, "hex1a3f");

    // Decimal conversion with ignored pulses during CONV
    tick(0, 1, 1, 16'd1234, "dec_hs");
    for (int c = 0; c < 16; c++)
      tick(0, (c % 3) == 1, c[0], 16'(16'h9999 ^ c), "dec_conv");
    repeat (20) tick(0, 0, 0, 16'h0, "dec1234");

    // Decimal overflow, then hex clears ovf
    tick(0, 1, 1, 16'd10000, "ovf_hs");
    repeat (18) tick(0, 0, 0, 16'h0, "ovf_dash");
    tick(0, 1, 0, 16'h0005, "hex5_hs");
    repeat (18) tick(0, 0, 0, 16'h0, "hex0005");

    // Boundary: exactly 9999 converts
    tick(0, 1, 1, 16'd9999, "dec9999_hs");
    repeat (34) tick(0, 0, 0, 16'h0, "dec9999");

    // Reset in the middle of a conversion
    tick(0, 1, 1, 16'd4321, "abort_hs");
    repeat (7) tick(0, 0, 0, 16'h0, "abort_conv");
    repeat (2) tick(1, 0, 0, 16'h0, "abort_rst");
    repeat (20) tick(0, 0, 0, 16'h0, "abort_after");

    // Leading-zero case
    tick(0, 1, 0, 16'h000A, "lzb_hs");
    repeat (18) tick(0, 0, 0, 16'h0, "lzb000a");
    tick(0, 1, 0, 16'h0300, "lzb_hs2");
    repeat (18) tick(0, 0, 0, 16'h0, "lzb0300");

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rr   = ($urandom_range(0, 99) < 2);
      rv   = ($urandom_range(0, 2) == 0);
      rdec = 1'($urandom_range(0, 1));
      if (rdec && ($urandom_range(0, 3) != 0)) rd = 16'($urandom_range(0, 9999));
      else rd = 16'($urandom_range(0, 65535));
      tick(rr, rv, rdec, rd, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
